// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter feeding one synchronous FIFO write port
// Optional burst mode: define FIFO_ARB_BURST_EN to let a grantee keep priority for up
// to MAX_BURST consecutive accepts; undefined gives plain round robin.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*WIDTH-1:0]   data_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       fifo_wr_en_o,
  output logic [WIDTH-1:0]           fifo_wdata_o,
  input  logic                       fifo_rd_en_i,
  input  logic                       fifo_full_i,
  input  logic                       fifo_empty_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = {1'b0, DEPTH_C};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      sel;
  logic [PW-1:0]      ptr_inc;
  logic [NUM_REQ-1:0] sel_oh;
  logic               found;
  logic               space;
  logic               accept;
  logic               rd_eff;
  logic [CW:0]        occ_sum;

  // The word already on the write port counts as occupied; a same-cycle read is not credited.
  assign occ_sum = {1'b0, count_o} + {{CW{1'b0}}, fifo_wr_en_o};
  assign space   = (occ_sum < DEPTH_X) && !fifo_full_i;
  assign rd_eff  = fifo_rd_en_i && !fifo_empty_i;
  assign ptr_inc = (int'(sel) == NUM_REQ - 1) ? '0 : sel + PW'(1);

  // Find the first requester at or after the pointer, wrapping around.
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
    sel_oh = NUM_REQ'(1) << sel;
  end

  // Next state and grant: a grant is issued exactly when the arbiter is in (or enters) WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|req_i) state_d = space ? WRITE : STALL;
      end
      WRITE: begin
        if (!(|req_i))  state_d = IDLE;
        else if (!space) state_d = STALL;
      end
      STALL: begin
        if (!(|req_i)) state_d = IDLE;
        else if (space) state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
    accept = rst_i && found && (state_d == WRITE);
    gnt_o  = accept ? sel_oh : '0;
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_BURST_C = BW'(MAX_BURST);

  logic [BW-1:0] burst_q, burst_d, burst_next;
  logic [PW-1:0] ptr_q_inc;

  assign ptr_q_inc = (int'(ptr_q) == NUM_REQ - 1) ? '0 : ptr_q + PW'(1);

  // The grantee keeps the pointer until its burst fills or its request drops; stalls leave it alone.
  always_comb begin
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    burst_next = (sel == ptr_q) ? burst_q + BW'(1) : BW'(1);
    if (accept) begin
      if (burst_next == MAX_BURST_C) begin
        ptr_d   = ptr_inc;
        burst_d = '0;
      end else begin
        ptr_d   = sel;
        burst_d = burst_next;
      end
    end else if ((burst_q != '0) && !req_i[ptr_q]) begin
      ptr_d   = ptr_q_inc;
      burst_d = '0;
    end
  end

  // Burst length register, cleared whenever priority rotates.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) burst_q <= '0;
    else        burst_q <= burst_d;
  end
`else
  // MAX_BURST only shapes the burst build.
  wire unused_max_burst = (MAX_BURST > 0);

  assign ptr_d = accept ? ptr_inc : ptr_q;
`endif

  // FSM, pointer and registered write port; an in-flight word is dropped by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      fifo_wr_en_o <= 1'b0;
      fifo_wdata_o <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fifo_wr_en_o <= accept;
      if (accept) fifo_wdata_o <= data_i[int'(sel)*WIDTH +: WIDTH];
    end
  end

  // Shadow occupancy (saturating) and sticky overflow / mismatch error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_o <= '0;
      err_o   <= 1'b0;
    end else begin
      if (fifo_wr_en_o && !rd_eff) begin
        if (count_o != DEPTH_C) count_o <= count_o + CW'(1);
      end else if (rd_eff && !fifo_wr_en_o) begin
        if (count_o != '0) count_o <= count_o - CW'(1);
      end
      if ((fifo_wr_en_o && fifo_full_i && !rd_eff) ||
          (fifo_empty_i && (count_o != '0) && !fifo_wr_en_o))
        err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int NUM_REQ   = 4;
  localparam int DEPTH     = 16;
  localparam int MAX_BURST = 4;
  localparam int CW        = $clog2(DEPTH + 1);

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     wr_en;
  logic [WIDTH-1:0]         wdata;
  logic                     rd_en;
  logic                     full;
  logic                     empty;
  logic [CW-1:0]            count;
  logic                     err;

  fifo_wr_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .data_i(data), .gnt_o(gnt),
    .fifo_wr_en_o(wr_en), .fifo_wdata_o(wdata), .fifo_rd_en_i(rd_en),
    .fifo_full_i(full), .fifo_empty_i(empty), .count_o(count), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // Reference model state: what the arbiter should hold after each edge.
  int         m_count;
  int         m_wr;
  logic [7:0] m_wdata;
  int         m_err;
  int         m_ptr;
  int         m_bcnt;
  int         occ;

  typedef struct {
    logic [3:0] req;
    logic       rd;
    logic       empty;
    logic [3:0] gnt;
    logic       wr;
    logic [7:0] wdata;
    int         count;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wr = 0; m_wdata = 8'h00; m_err = 0; m_ptr = 0; m_bcnt = 0;
  endtask

  function automatic logic [3:0] model_gnt();
    if (!rst_n || full || (m_count + m_wr) >= DEPTH) return 4'b0000;
    for (int off = 0; off < NUM_REQ; off++) begin
      int k = (m_ptr + off) % NUM_REQ;
      if (req[k]) return 4'(1 << k);
    end
    return 4'b0000;
  endfunction

  task automatic set_flags();
    full  = (occ >= DEPTH);
    empty = (occ == 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, " gnt"},   int'(gnt),   int'(model_gnt()));
    check({tag, " wr_en"}, int'(wr_en), m_wr);
    check({tag, " wdata"}, int'(wdata), int'(m_wdata));
    check({tag, " count"}, int'(count), m_count);
    check({tag, " err"},   int'(err),   m_err);
  endtask

  // Advance one clock: model and the FIFO occupancy both move on the rising edge.
  task automatic tick();
    logic [3:0] g;
    int k, n_count, n_wr, n_err, n_ptr, n_bcnt, n_occ, rd_eff;
    logic [7:0] n_wdata;
    if (!rst_n) begin
      model_reset();
      occ = 0;
      @(posedge clk);
      @(negedge clk);
      return;
    end
    rd_eff  = (rd_en && !empty) ? 1 : 0;
    g       = model_gnt();
    k       = 0;
    for (int i = 0; i < NUM_REQ; i++) if (g[i]) k = i;
    n_err   = m_err;
    if ((m_wr == 1 && full && rd_eff == 0) || (empty && m_count != 0 && m_wr == 0)) n_err = 1;
    n_count = m_count;
    if (m_wr == 1 && rd_eff == 0) n_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
    else if (rd_eff == 1 && m_wr == 0) n_count = (m_count > 0) ? m_count - 1 : 0;
    n_wr    = (g != 0) ? 1 : 0;
    n_wdata = (g != 0) ? data[k*WIDTH +: WIDTH] : m_wdata;
    n_ptr   = m_ptr;
    n_bcnt  = m_bcnt;
`ifdef FIFO_ARB_BURST_EN
    if (g != 0) begin
      n_bcnt = (k == m_ptr) ? m_bcnt + 1 : 1;
      if (n_bcnt >= MAX_BURST) begin
        n_ptr = (k + 1) % NUM_REQ; n_bcnt = 0;
      end else begin
        n_ptr = k;
      end
    end else if (m_bcnt != 0 && !req[m_ptr]) begin
      n_ptr = (m_ptr + 1) % NUM_REQ; n_bcnt = 0;
    end
`else
    if (g != 0) n_ptr = (k + 1) % NUM_REQ;
`endif
    n_occ = occ + m_wr - rd_eff;
    if (n_occ > DEPTH) n_occ = DEPTH;
    if (n_occ < 0) n_occ = 0;
    @(posedge clk);
    m_count = n_count; m_wr = n_wr; m_wdata = n_wdata; m_err = n_err;
    m_ptr = n_ptr; m_bcnt = n_bcnt; occ = n_occ;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    rd_en = 1'b0;
    model_reset();
    occ = 0;
    set_flags();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int grants;
    logic [3:0] g_prev;
    logic [3:0] held;
    int rd_pct;
    logic [3:0] burst_exp[8];

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = '0;
    rd_en = 1'b0;
    data  = {8'h44, 8'h33, 8'h22, 8'h11};
    occ   = 0;
    model_reset();
    set_flags();

    //          req    rd    empty gnt    wr    wdata  count
    tbl[0]  = '{4'hF, 1'b0, 1'b1, 4'h1, 1'b0, 8'h00, 0};
    tbl[1]  = '{4'hF, 1'b0, 1'b1, 4'h2, 1'b1, 8'h11, 0};
    tbl[2]  = '{4'hF, 1'b0, 1'b0, 4'h4, 1'b1, 8'h22, 1};
    tbl[3]  = '{4'hF, 1'b0, 1'b0, 4'h8, 1'b1, 8'h33, 2};
    tbl[4]  = '{4'hF, 1'b0, 1'b0, 4'h1, 1'b1, 8'h44, 3};
    tbl[5]  = '{4'hF, 1'b0, 1'b0, 4'h2, 1'b1, 8'h11, 4};
    tbl[6]  = '{4'hF, 1'b0, 1'b0, 4'h4, 1'b1, 8'h22, 5};
    tbl[7]  = '{4'hF, 1'b0, 1'b0, 4'h8, 1'b1, 8'h33, 6};
    tbl[8]  = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h44, 7};
    tbl[9]  = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h44, 8};
    tbl[10] = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h44, 7};
    tbl[11] = '{4'h1, 1'b0, 1'b0, 4'h1, 1'b0, 8'h44, 6};
    tbl[12] = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 8'h11, 6};
    tbl[13] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h11, 6};

    // Reset held with every requester asking.
    @(negedge clk);
    req = 4'hF;
    #1;
    check("reset gnt",   int'(gnt),   0);
    check("reset wr_en", int'(wr_en), 0);
    check("reset count", int'(count), 0);
    check("reset err",   int'(err),   0);
    tick();
    tick();
    rst_n = 1'b1;

`ifndef FIFO_ARB_BURST_EN
    // Round robin, write latency, read/write bookkeeping.
    for (int i = 0; i < 14; i++) begin
      req   = tbl[i].req;
      rd_en = tbl[i].rd;
      empty = tbl[i].empty;
      full  = 1'b0;
      #1;
      check($sformatf("tbl%0d gnt", i),   int'(gnt),   int'(tbl[i].gnt));
      check($sformatf("tbl%0d wr_en", i), int'(wr_en), int'(tbl[i].wr));
      check($sformatf("tbl%0d wdata", i), int'(wdata), int'(tbl[i].wdata));
      check($sformatf("tbl%0d count", i), int'(count), tbl[i].count);
      check($sformatf("tbl%0d err", i),   int'(err),   0);
      tick();
    end
`else
    // Burst: two requesters share the port in runs of MAX_BURST.
    do_reset();
    burst_exp = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2};
    for (int i = 0; i < 8; i++) begin
      req = 4'h3;
      set_flags();
      #1;
      check($sformatf("burst%0d gnt", i), int'(gnt), int'(burst_exp[i]));
      tick();
    end
`endif

    // Fill: a single requester gets exactly DEPTH writes, then stalls.
    do_reset();
    grants = 0;
    for (int i = 0; i < 20; i++) begin
      req = 4'h1;
      set_flags();
      #1;
      if (gnt == 4'h1) grants++;
      check_model("fill");
      tick();
    end
    set_flags();
    #1;
    check("fill grants", grants, DEPTH);
    check("fill gnt",    int'(gnt),   0);
    check("fill count",  int'(count), DEPTH);
    check("fill err",    int'(err),   0);

    // One read at full frees exactly one slot.
    rd_en = 1'b1;
    check_model("full rd");
    tick();
    rd_en  = 1'b0;
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      set_flags();
      #1;
      if (gnt == 4'h1) grants++;
      check_model("refill");
      tick();
    end
    set_flags();
    #1;
    check("refill grants", grants, 1);
    check("refill count",  int'(count), DEPTH);

    // Shadow mismatch: FIFO claims empty while three words are accounted for.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req = (i < 3) ? 4'h1 : 4'h0;
      set_flags();
      #1;
      check_model("errfill");
      tick();
    end
    set_flags();
    #1;
    check("err pre count", int'(count), 3);
    check("err pre err",   int'(err),   0);
    empty = 1'b1;
    tick();
    set_flags();
    #1;
    check("err set", int'(err), 1);
    for (int i = 0; i < 3; i++) tick();
    #1;
    check("err sticky", int'(err), 1);
    rst_n = 1'b0;
    #1;
    check("err cleared", int'(err),   0);
    check("err count",   int'(count), 0);
    tick();
    rst_n = 1'b1;

    // Randomized protocol-respecting traffic against the model.
    do_reset();
    g_prev = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        do_reset();
        g_prev = '0;
      end
      rd_pct = (cyc < 1000) ? 10 : ((cyc < 2000) ? 50 : 30);
      held   = req & ~g_prev;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (held[k]) begin
          req[k] = 1'b1;
        end else begin
          req[k] = ($urandom_range(0, 99) < 35);
          data[k*WIDTH +: WIDTH] = 8'($urandom);
        end
      end
      rd_en = ($urandom_range(0, 99) < rd_pct);
      set_flags();
      #1;
      check_model("rand");
      g_prev = model_gnt();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
